// File: rtl/adv7611_pkg.sv
// Shared types and helpers for the ADV7611 sync monitor: FSM states, geometry
// record, and the tolerance compare used for frame-to-frame matching.
package adv7611_pkg;

  localparam int unsigned H_W = 12;
  localparam int unsigned V_W = 11;

  typedef enum logic [1:0] {
    ST_NOSYNC  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  typedef struct packed {
    logic [H_W-1:0] h_total;
    logic [V_W-1:0] v_total;
    logic [V_W-1:0] h_active;
    logic [V_W-1:0] v_active;
  } geom_t;

  // Operands are zero-extended to 13 bits, so the signed difference cannot wrap.
  function automatic logic within_tol(input logic [12:0] a, input logic [12:0] b,
                                      input logic [12:0] tol);
    logic signed [12:0] d;
    logic [12:0] mag;
    d   = $signed(a) - $signed(b);
    mag = d[12] ? $unsigned(-d) : $unsigned(d);
    return mag <= tol;
  endfunction

  function automatic logic geom_match(input geom_t a, input geom_t b,
                                      input logic [12:0] htol, input logic [12:0] vtol);
    return within_tol({1'b0, a.h_total}, {1'b0, b.h_total}, htol)
        && within_tol({2'b00, a.v_total}, {2'b00, b.v_total}, vtol)
        && (a.h_active == b.h_active)
        && within_tol({2'b00, a.v_active}, {2'b00, b.v_active}, vtol);
  endfunction

  // A pegged counter means the measurement is meaningless; never lock on it.
  function automatic logic geom_saturated(input geom_t g);
    return (g.h_total == '1) || (g.v_total == '1) || (g.h_active == '1) || (g.v_active == '1);
  endfunction

endpackage

// File: rtl/adv7611_sync_meas.sv
// Raw sync/DE edge detection and per-frame geometry measurement; snap is
// updated on each VSYNC falling edge and frame_valid strobes one cycle later.
module adv7611_sync_meas
  import adv7611_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  hsync,
  input  logic  vsync,
  input  logic  de,
  output logic  vsync_edge,
  output logic  frame_valid,
  output geom_t snap
);

  logic           hsync_prev, vsync_prev, de_prev;
  logic           h_edge, de_edge;
  logic [H_W-1:0] hcnt, meas_h;
  logic [V_W-1:0] lcnt, lcnt_inc, decnt, meas_ha, acnt, acnt_inc;

  assign h_edge     = hsync_prev & ~hsync;
  assign vsync_edge = vsync_prev & ~vsync;
  assign de_edge    = de_prev & ~de;

  assign lcnt_inc = (h_edge && lcnt != '1) ? lcnt + 1'b1 : lcnt;
  assign acnt_inc = (de_edge && acnt != '1) ? acnt + 1'b1 : acnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_prev  <= 1'b0;
      vsync_prev  <= 1'b0;
      de_prev     <= 1'b0;
      frame_valid <= 1'b0;
      hcnt        <= '0;
      meas_h      <= '0;
      lcnt        <= '0;
      decnt       <= '0;
      meas_ha     <= '0;
      acnt        <= '0;
      snap        <= '0;
    end else begin
      hsync_prev  <= hsync;
      vsync_prev  <= vsync;
      de_prev     <= de;
      frame_valid <= vsync_edge;

      if (h_edge) begin
        meas_h <= (hcnt == '1) ? hcnt : hcnt + 1'b1;
        hcnt   <= '0;
      end else if (hcnt != '1) begin
        hcnt <= hcnt + 1'b1;
      end

      if (de_edge) begin
        meas_ha <= decnt;
        decnt   <= '0;
      end else if (de && decnt != '1) begin
        decnt <= decnt + 1'b1;
      end

      // A line or DE edge coinciding with the frame edge belongs to the new frame.
      if (vsync_edge) begin
        snap <= '{h_total: meas_h, v_total: lcnt, h_active: meas_ha, v_active: acnt};
        lcnt <= V_W'(h_edge);
        acnt <= V_W'(de_edge);
      end else begin
        lcnt <= lcnt_inc;
        acnt <= acnt_inc;
      end
    end
  end

endmodule

// File: rtl/adv7611_sync_monitor.sv
// Lock sequencer for the ADV7611 input path: compares successive frame
// snapshots, declares lock after LOCK_FRAMES matches and latches the mode.
module adv7611_sync_monitor
  import adv7611_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 3,
  parameter int unsigned H_TOL       = 2,
  parameter int unsigned V_TOL       = 1,
  parameter int unsigned TIMEOUT_CYC = 4000000
) (
  input  logic        PCLK_i,
  input  logic        reset_i,
  input  logic        HSYNC_i,
  input  logic        VSYNC_i,
  input  logic        DE_i,
  input  logic        interlace_flag_i,
  output logic        lock_o,
  output logic [1:0]  state_o,
  output logic [11:0] h_total_o,
  output logic [10:0] v_total_o,
  output logic [10:0] h_active_o,
  output logic [10:0] v_active_o,
  output logic        interlaced_o,
  output logic        mode_change_o
);

  localparam int unsigned T_W = $clog2(TIMEOUT_CYC + 1);

  state_t         state;
  geom_t          snap, ref_g, out_g, acq_ref;
  logic           vsync_edge, frame_valid;
  logic           snap_ok, match_ref, match_out, timeout;
  logic [3:0]     stable_cnt, acq_cnt;
  logic [T_W-1:0] tcnt;

  adv7611_sync_meas u_meas (
    .clk         (PCLK_i),
    .rst         (reset_i),
    .hsync       (HSYNC_i),
    .vsync       (VSYNC_i),
    .de          (DE_i),
    .vsync_edge  (vsync_edge),
    .frame_valid (frame_valid),
    .snap        (snap)
  );

  assign snap_ok   = !geom_saturated(snap);
  assign match_ref = snap_ok && geom_match(snap, ref_g, 13'(H_TOL), 13'(V_TOL));
  assign match_out = snap_ok && geom_match(snap, out_g, 13'(H_TOL), 13'(V_TOL));
  assign timeout   = (tcnt == T_W'(TIMEOUT_CYC));

  always_comb begin
    acq_ref = snap;
    acq_cnt = snap_ok ? 4'd1 : 4'd0;
    if (stable_cnt != '0 && match_ref) begin
      acq_ref = ref_g;
      acq_cnt = stable_cnt + 4'd1;
    end
  end

  assign state_o    = state;
  assign h_total_o  = out_g.h_total;
  assign v_total_o  = out_g.v_total;
  assign h_active_o = out_g.h_active;
  assign v_active_o = out_g.v_active;

  always_ff @(posedge PCLK_i) begin
    if (reset_i) begin
      state         <= ST_NOSYNC;
      ref_g         <= '0;
      out_g         <= '0;
      stable_cnt    <= '0;
      tcnt          <= '0;
      lock_o        <= 1'b0;
      interlaced_o  <= 1'b0;
      mode_change_o <= 1'b0;
    end else begin
      mode_change_o <= 1'b0;

      if (vsync_edge)   tcnt <= '0;
      else if (!timeout) tcnt <= tcnt + 1'b1;

      // Timeout dominates; latched geometry is deliberately left untouched.
      if (timeout) begin
        state      <= ST_NOSYNC;
        lock_o     <= 1'b0;
        stable_cnt <= '0;
      end else if (frame_valid) begin
        case (state)
          ST_NOSYNC: begin
            state      <= ST_ACQUIRE;
            stable_cnt <= '0;
          end
          ST_ACQUIRE: begin
            ref_g      <= acq_ref;
            stable_cnt <= acq_cnt;
            if (acq_cnt >= 4'(LOCK_FRAMES)) begin
              state         <= ST_LOCKED;
              out_g         <= acq_ref;
              interlaced_o  <= interlace_flag_i;
              lock_o        <= 1'b1;
              mode_change_o <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (!match_out) begin
              state      <= ST_ACQUIRE;
              lock_o     <= 1'b0;
              ref_g      <= snap;
              stable_cnt <= 4'd1;
            end
          end
          default: state <= ST_NOSYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adv7611_sync_monitor.sv
// Directed bench for adv7611_sync_monitor using scaled-down frame geometries;
// each vector is one generated frame plus the outputs expected after its leading VSYNC edge.
module tb_adv7611_sync_monitor;

  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b1, vs = 1'b1, de = 1'b0, il = 1'b0;
  logic        lock_o, interlaced_o, mode_change_o;
  logic [1:0]  state_o;
  logic [11:0] h_total_o;
  logic [10:0] v_total_o, h_active_o, v_active_o;

  int passed = 0;
  int total  = 0;
  int mc_seen = 0;

  adv7611_sync_monitor #(
    .LOCK_FRAMES (3),
    .H_TOL       (2),
    .V_TOL       (1),
    .TIMEOUT_CYC (TO)
  ) dut (
    .PCLK_i           (clk),
    .reset_i          (rst),
    .HSYNC_i          (hs),
    .VSYNC_i          (vs),
    .DE_i             (de),
    .interlace_flag_i (il),
    .lock_o           (lock_o),
    .state_o          (state_o),
    .h_total_o        (h_total_o),
    .v_total_o        (v_total_o),
    .h_active_o       (h_active_o),
    .v_active_o       (v_active_o),
    .interlaced_o     (interlaced_o),
    .mode_change_o    (mode_change_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mode_change_o === 1'b1) mc_seen++;

  // Frame stimulus (h, v, ha, va, lines emitted, interlace) and expected outputs.
  typedef struct {
    int h, v, ha, va, nl;
    bit il;
    int st;
    bit lk;
    int eh, ev, eha, eva;
    bit eil, mc;
  } vec_t;

  vec_t vecs[37];

  function automatic vec_t mk(int h, int v, int ha, int va, int nl, bit fil,
                              int st, bit lk, int eh, int ev, int eha, int eva, bit eil, bit mc);
    vec_t r;
    r.h = h; r.v = v; r.ha = ha; r.va = va; r.nl = nl; r.il = fil;
    r.st = st; r.lk = lk; r.eh = eh; r.ev = ev; r.eha = eha; r.eva = eva;
    r.eil = eil; r.mc = mc;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    else passed++;
  endtask

  task automatic check_outputs(input int idx, input int st, input bit lk, input int eh, input int ev,
                               input int eha, input int eva, input bit eil, input bit mc);
    check("state", idx, {30'd0, state_o}, st);
    check("lock", idx, {31'd0, lock_o}, {31'd0, lk});
    check("h_total", idx, {20'd0, h_total_o}, eh);
    check("v_total", idx, {21'd0, v_total_o}, ev);
    check("h_active", idx, {21'd0, h_active_o}, eha);
    check("v_active", idx, {21'd0, v_active_o}, eva);
    check("interlaced", idx, {31'd0, interlaced_o}, {31'd0, eil});
    check("mode_change", idx, {31'd0, mode_change_o}, {31'd0, mc});
  endtask

  // VSYNC low on lines 0..2, HSYNC low on pixels 0..1, DE from line 3 / pixel 4.
  // Outputs are sampled two cycles after the frame's leading VSYNC edge.
  task automatic drive_frame(input vec_t r, input int idx);
    for (int l = 0; l < r.nl; l++) begin
      for (int p = 0; p < r.h; p++) begin
        @(negedge clk);
        if (l == 0 && p == 2)
          check_outputs(idx, r.st, r.lk, r.eh, r.ev, r.eha, r.eva, r.eil, r.mc);
        hs = (p >= 2);
        vs = (l >= 3);
        de = (l >= 3 && l < 3 + r.va && p >= 4 && p < 4 + r.ha);
        il = r.il;
      end
    end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) drive_frame(vecs[i], i + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hs = 1'b1; vs = 1'b1; de = 1'b0;
    end
  endtask

  initial begin
    int  waited;
    bit  dropped;

    // A ~ progressive mode, B ~ mode after switch, I ~ interlaced fields.
    vecs[0]  = mk(24,14,16,9,14,0, 1,0,  0, 0, 0,0,0,0);
    vecs[1]  = mk(24,14,16,9,14,0, 1,0,  0, 0, 0,0,0,0);
    vecs[2]  = mk(24,14,16,9,14,0, 1,0,  0, 0, 0,0,0,0);
    vecs[3]  = mk(24,14,16,9,14,0, 2,1, 24,14,16,9,0,1);
    vecs[4]  = mk(24,14,16,9,14,0, 2,1, 24,14,16,9,0,0);
    vecs[5]  = mk(26,14,16,9,14,0, 2,1, 24,14,16,9,0,0);
    vecs[6]  = mk(22,14,16,9,14,0, 2,1, 24,14,16,9,0,0);
    vecs[7]  = mk(24,14,16,9,14,0, 2,1, 24,14,16,9,0,0);
    vecs[8]  = mk(27,14,16,9,14,0, 2,1, 24,14,16,9,0,0);
    vecs[9]  = mk(24,14,16,9,14,0, 1,0, 24,14,16,9,0,0);
    vecs[10] = mk(24,14,16,9,14,0, 1,0, 24,14,16,9,0,0);
    vecs[11] = mk(24,14,16,9,14,0, 1,0, 24,14,16,9,0,0);
    vecs[12] = mk(24,14,16,9,14,0, 2,1, 24,14,16,9,0,1);
    vecs[13] = mk(24,14,16,9, 7,0, 2,1, 24,14,16,9,0,0);
    vecs[14] = mk(20,12,12,8,12,0, 1,0, 24,14,16,9,0,0);
    vecs[15] = mk(20,12,12,8,12,0, 1,0, 24,14,16,9,0,0);
    vecs[16] = mk(20,12,12,8,12,0, 1,0, 24,14,16,9,0,0);
    vecs[17] = mk(20,12,12,8,12,0, 2,1, 20,12,12,8,0,1);
    vecs[18] = mk(24,12,16,7,12,1, 2,1, 20,12,12,8,0,0);
    vecs[19] = mk(24,11,16,7,11,1, 1,0, 20,12,12,8,0,0);
    vecs[20] = mk(24,12,16,7,12,1, 1,0, 20,12,12,8,0,0);
    vecs[21] = mk(24,11,16,7,11,1, 2,1, 24,12,16,7,1,1);
    vecs[22] = mk(24,12,16,7,12,1, 2,1, 24,12,16,7,1,0);
    vecs[23] = mk(24,11,16,7,11,1, 2,1, 24,12,16,7,1,0);
    vecs[24] = mk(24,14,16,9,14,0, 2,1, 24,12,16,7,1,0);
    vecs[25] = mk(24,14,16,9,14,0, 1,0, 24,12,16,7,1,0);
    vecs[26] = mk(24,14,16,9,14,0, 1,0, 24,12,16,7,1,0);
    vecs[27] = mk(24,14,16,9,14,0, 2,1, 24,14,16,9,0,1);
    vecs[28] = mk(24,14,16,9,14,0, 1,0, 24,14,16,9,0,0);
    vecs[29] = mk(24,14,16,9,14,0, 1,0, 24,14,16,9,0,0);
    vecs[30] = mk(24,14,16,9,14,0, 1,0, 24,14,16,9,0,0);
    vecs[31] = mk(24,14,16,9,14,0, 2,1, 24,14,16,9,0,1);
    vecs[32] = mk(24,14,16,9, 5,0, 2,1, 24,14,16,9,0,0);
    vecs[33] = mk(24,14,16,9,14,0, 1,0,  0, 0, 0,0,0,0);
    vecs[34] = mk(24,14,16,9,14,0, 1,0,  0, 0, 0,0,0,0);
    vecs[35] = mk(24,14,16,9,14,0, 1,0,  0, 0, 0,0,0,0);
    vecs[36] = mk(24,14,16,9,14,0, 2,1, 24,14,16,9,0,1);

    @(negedge clk);
    @(negedge clk);
    check_outputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    idle(4);

    // Lock, jitter, mode switch, interlace, mode change back.
    run(0, 27);

    // VSYNC stops while locked.
    idle(0);
    waited  = 0;
    dropped = 1'b0;
    while (waited < TO + 100 && !dropped) begin
      @(negedge clk);
      waited++;
      if (state_o == 2'd0) dropped = 1'b1;
    end
    check("timeout_fired", 0, {31'd0, dropped}, 32'd1);
    check("timeout_latency", 0, {31'd0, (waited >= TO - 345 && waited <= TO - 320)}, 32'd1);
    check_outputs(0, 0, 0, 24, 14, 16, 9, 0, 0);
    idle(3);

    run(28, 32);

    // One-cycle reset in the middle of a locked frame.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs(100, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    run(33, 36);
    idle(2);

    check("mode_change_count", 0, mc_seen, 32'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adv7611_sync_monitor.md
Name: adv7611_sync_monitor

Overview:
- Timing supervisor and lock sequencer for the ADV7611 video input path.
- Taps the raw sync/DE stream driving the frontend and measures line/frame geometry every frame.
- Runs a NOSYNC/ACQUIRE/LOCKED state machine and publishes stable, latched mode parameters plus a lock flag.
- Scan-converter control (CPU regs, line buffer config) acts only on these latched values; it never uses raw counters.

Parameters:
- LOCK_FRAMES, 3, consecutive matching frames required to declare lock (1..15)
- H_TOL, 2, allowed |delta| in h_total (PCLK cycles) between compared frames
- V_TOL, 1, allowed |delta| in v_total (lines); covers interlace field alternation
- TIMEOUT_CYC, 4000000, PCLK cycles without any VSYNC falling edge before forcing NOSYNC

Ports:
- PCLK_i  in  1  pixel clock; sole clock
- reset_i  in  1  synchronous, active-high reset
- HSYNC_i  in  1  raw hsync; event = falling edge
- VSYNC_i  in  1  raw vsync; event = falling edge
- DE_i  in  1  raw data enable
- interlace_flag_i  in  1  interlace indication from frontend
- lock_o  out  1  mode locked and stable
- state_o  out  2  0=NOSYNC, 1=ACQUIRE, 2=LOCKED
- h_total_o  out  12  latched PCLKs per line
- v_total_o  out  11  latched lines per frame/field
- h_active_o  out  11  latched DE-high cycles per line
- v_active_o  out  11  latched DE lines per frame/field
- interlaced_o  out  1  interlace_flag_i latched at lock
- mode_change_o  out  1  1-cycle pulse on every entry to LOCKED

Behaviour:
- Reset: every output 0, state NOSYNC, all counters/refs 0. Reset mid-frame discards the partial measurement; measurement restarts at the next VSYNC edge.
- Inputs are registered once into *_prev. An edge is detected in cycle N when prev=1 and current=0.
- Running counters:
  - hcnt: +1 each cycle, saturates at 4095. On HSYNC edge, meas_h <= hcnt+1 and hcnt <= 0.
  - lcnt: HSYNC edges counted in the frame, saturates at 2047.
  - decnt: DE-high cycles in the current line. On DE falling edge, meas_ha <= decnt, decnt <= 0, acnt +1.
- Frame end = VSYNC edge in cycle N:
  - Snapshot {meas_h, lcnt, meas_ha, acnt} into frame regs at end of N.
  - lcnt and acnt are cleared. If an HSYNC edge coincides in cycle N, it counts for the new frame (lcnt <= 1).
  - The comparison/FSM update happens in N+1; outputs are visible at N+2.
- Match rule: |h-ref_h|<=H_TOL, |v-ref_v|<=V_TOL, h_active equal, |v_active-ref_va|<=V_TOL. Subtractions are 13-bit signed, no wrap.
- NOSYNC: on the first VSYNC edge go to ACQUIRE with stable_cnt=0; that frame's snapshot is discarded as partial.
- ACQUIRE, on each frame end:
  - stable_cnt==0: ref <= snap, stable_cnt=1.
  - match: stable_cnt+1.
  - mismatch: ref <= snap, stable_cnt=1.
  - When stable_cnt reaches LOCK_FRAMES, go to LOCKED. Latch outputs from ref, set interlaced_o and lock_o=1, pulse mode_change_o.
- LOCKED, on each frame end:
  - match vs latched outputs: stay; outputs are not updated.
  - mismatch: go to ACQUIRE, lock_o=0, ref <= snap, stable_cnt=1. Latched geometry outputs hold their last values.
- Timeout: the counter is cleared on every VSYNC edge and saturates. Reaching TIMEOUT_CYC in any state forces NOSYNC with lock_o=0. Geometry outputs hold.
- Counter saturation at 4095/2047 forces a mismatch, so lock is never declared on saturated values.

Decomposition:
- Package adv7611_pkg holds:
  - state enum (NOSYNC/ACQUIRE/LOCKED, 2 bits)
  - width constants H_W=12, V_W=11
  - struct/typedef for geometry {h_total, v_total, h_active, v_active}
- One sub-module, adv7611_sync_meas: edge detection, counters and the per-frame snapshot, with a frame_valid strobe.
- The top holds the FSM, tolerance compare, stable counter, timeout and output latch.

Test Plan:
- Clean 1080p (2200x1125, DE 1920x1080), LOCK_FRAMES=3 -> lock_o rises 2 cycles after the 4th VSYNC edge. Outputs are 2200/1125/1920/1080, with one mode_change_o pulse.
- 1080i fields alternating v_total 562/563 -> lock achieved with interlaced_o=1. Later mismatch of 1 line never drops lock.
- Locked 1080p, then switch to 720p (1650x750, 1280x720) mid-frame -> next frame end returns to ACQUIRE with lock_o=0. Relock at 720p values after 3 more frames, with a second mode_change_o pulse.
- h_total jitter +-2 cycles while locked -> lock held. A +3 cycle jitter -> drop to ACQUIRE on that frame.
- VSYNC stopped for TIMEOUT_CYC cycles while locked -> state_o=0 and lock_o=0, geometry outputs unchanged. Restored sync relocks.
- reset_i asserted for 1 cycle mid-frame while locked -> next cycle all outputs are 0 and state NOSYNC. Lock is reacquired on the 4th subsequent VSYNC edge.
